// File: rtl/pipeline_hazard_sequencer.sv
// Purpose : central stall/flush sequencer for the 5-stage pipeline. It watches the ID
//           opcode and freezes PC and IF/ID for HLT, MULT, load hazards and JUMP.
//           It also injects bubbles into ID/EX for those hazards.
// Latency : stall/bubble/mc_start are Mealy, in the same cycle as the hazard.
//           stall_pm and halted are registered one cycle later.
// Backpressure: none accepted. Every stall sequence ends with one RELEASE cycle (stall=0)
//           before any new hazard can be detected.
// Ports   : clk, reset (async active-low); id_valid, op, id_rs, id_rt (ID stage);
//           ex_is_load, ex_rt (EX stage); mc_done (multi-cycle unit); resume (leave HALT);
//           outputs: stall, bubble, stall_pm, halted, mc_start, state (debug).
// Config  : define LOAD_DEP_CHECK_EN to stall only on a true load-use dependency.
//           When it is undefined, every LD stalls one cycle.
module pipeline_hazard_sequencer #(
    parameter int unsigned JUMP_SLOTS = 2    // stall cycles per jump, legal 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [5:0] op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rt,
    input  logic       mc_done,
    input  logic       resume,
    output logic       stall,
    output logic       bubble,
    output logic       stall_pm,
    output logic       halted,
    output logic       mc_start,
    output logic [2:0] state
);

    localparam logic [5:0] OP_HLT  = 6'b010001;
    localparam logic [5:0] OP_LD   = 6'b010100;
    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam logic [3:0] OP_JUMP_HI = 4'b0111;  // JUMP = 0111xx
    localparam logic [3:0] JUMP_LOAD  = 4'(JUMP_SLOTS - 1);

    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_JUMP_FLUSH = 3'd1,
        S_MC_BUSY    = 3'd2,
        S_HALT       = 3'd3,
        S_RELEASE    = 3'd4
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       stall_c;
    logic       mc_start_c;
    logic       load_hazard;

`ifdef LOAD_DEP_CHECK_EN
    // Only the instruction that actually consumes the loaded register waits.
    // r0 is hard-wired zero, so it never creates a dependency.
    assign load_hazard = ex_is_load && (ex_rt != 5'd0) &&
                         ((ex_rt == id_rs) || (ex_rt == id_rt));
`else
    // Conservative mode: every load stalls one cycle in ID, and the
    // dependency ports are kept only for interface compatibility.
    logic unused_dep_ports;
    assign unused_dep_ports = ^{ex_is_load, ex_rt, id_rs, id_rt};
    assign load_hazard      = (op == OP_LD);
`endif

    always_comb begin
        nxt_state  = cur_state;
        cnt_nxt    = cnt;
        stall_c    = 1'b0;
        mc_start_c = 1'b0;
        case (cur_state)
            S_RUN: begin
                if (id_valid) begin
                    // Priority: HLT > MULT > load hazard > JUMP
                    if (op == OP_HLT) begin
                        stall_c   = 1'b1;
                        nxt_state = S_HALT;
                    end else if (op == OP_MULT) begin
                        stall_c    = 1'b1;
                        mc_start_c = 1'b1;
                        nxt_state  = S_MC_BUSY;
                    end else if (load_hazard) begin
                        stall_c   = 1'b1;
                        nxt_state = S_RELEASE;
                    end else if (op[5:2] == OP_JUMP_HI) begin
                        stall_c   = 1'b1;
                        cnt_nxt   = JUMP_LOAD;
                        // This RUN cycle already counts as one stall slot.
                        nxt_state = (JUMP_SLOTS == 1) ? S_RELEASE : S_JUMP_FLUSH;
                    end
                end
            end
            S_JUMP_FLUSH: begin
                stall_c = 1'b1;
                cnt_nxt = cnt - 4'd1;
                // <= 1 rather than == 1 so a zero count cannot wrap into a long stall.
                if (cnt <= 4'd1) begin
                    nxt_state = S_RELEASE;
                end
            end
            S_MC_BUSY: begin
                stall_c = 1'b1;
                if (mc_done) begin
                    nxt_state = S_RELEASE;
                end
            end
            S_HALT: begin
                stall_c = 1'b1;
                if (resume) begin
                    nxt_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // The held instruction advances once. Detection is suppressed.
                nxt_state = S_RUN;
            end
            default: begin
                nxt_state = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_RUN;
            cnt       <= 4'd0;
            stall_pm  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            stall_pm  <= stall;
            halted    <= (nxt_state == S_HALT);
        end
    end

    // Gate the Mealy outputs with reset so an asserted reset quiets the pipeline
    // immediately, even when the ID opcode would otherwise raise a hazard.
    assign stall    = stall_c & reset;
    assign bubble   = stall_c & reset;
    assign mc_start = mc_start_c & reset;
    assign state    = cur_state;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
module tb_pipeline_hazard_sequencer;

    localparam logic [5:0] HLT  = 6'b010001;
    localparam logic [5:0] LD   = 6'b010100;
    localparam logic [5:0] MULT = 6'b011000;
    localparam logic [5:0] JMP  = 6'b011100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] op = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       ex_is_load = 1'b0;
    logic [4:0] ex_rt = '0;
    logic       mc_done = 1'b0;
    logic       resume = 1'b0;

    logic       s0, b0, p0, h0, m0;
    logic [2:0] st0;
    logic       s1, b1, p1, h1, m1;
    logic [2:0] st1;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.JUMP_SLOTS(2)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .op(op),
        .id_rs(id_rs), .id_rt(id_rt), .ex_is_load(ex_is_load), .ex_rt(ex_rt),
        .mc_done(mc_done), .resume(resume),
        .stall(s0), .bubble(b0), .stall_pm(p0), .halted(h0), .mc_start(m0), .state(st0)
    );

    pipeline_hazard_sequencer #(.JUMP_SLOTS(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .op(op),
        .id_rs(id_rs), .id_rt(id_rt), .ex_is_load(ex_is_load), .ex_rt(ex_rt),
        .mc_done(mc_done), .resume(resume),
        .stall(s1), .bubble(b1), .stall_pm(p1), .halted(h1), .mc_start(m1), .state(st1)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       stall;
        logic       bubble;
        logic       mc_start;
        logic       stall_pm;
        logic       halted;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: per DUT, "what the pipeline is waiting for" plus the stall history.
    int js[2] = '{2, 1};
    bit w_halt[2];
    bit w_mc[2];
    bit w_rel[2];
    int jleft[2];
    bit prev_stall[2];

    function automatic bit load_haz();
`ifdef LOAD_DEP_CHECK_EN
        return ex_is_load && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
`else
        return op == LD;
`endif
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = '0;
            if (!reset) begin
                w_halt[d] = 0; w_mc[d] = 0; w_rel[d] = 0; jleft[d] = 0;
                prev_stall[d] = 0;
            end else begin
                e.st = w_rel[d] ? 3'd4 : w_halt[d] ? 3'd3 : w_mc[d] ? 3'd2 :
                       (jleft[d] > 0) ? 3'd1 : 3'd0;
                e.halted   = w_halt[d];
                e.stall_pm = prev_stall[d];
                if (w_rel[d]) begin
                    w_rel[d] = 0;
                end else if (w_halt[d]) begin
                    e.stall = 1;
                    if (resume) begin w_halt[d] = 0; w_rel[d] = 1; end
                end else if (w_mc[d]) begin
                    e.stall = 1;
                    if (mc_done) begin w_mc[d] = 0; w_rel[d] = 1; end
                end else if (jleft[d] > 0) begin
                    e.stall = 1;
                    jleft[d]--;
                    if (jleft[d] == 0) w_rel[d] = 1;
                end else if (id_valid) begin
                    if (op == HLT) begin
                        e.stall = 1; w_halt[d] = 1;
                    end else if (op == MULT) begin
                        e.stall = 1; e.mc_start = 1; w_mc[d] = 1;
                    end else if (load_haz()) begin
                        e.stall = 1; w_rel[d] = 1;
                    end else if (op[5:2] == 4'b0111) begin
                        e.stall = 1;
                        jleft[d] = js[d] - 1;
                        if (jleft[d] == 0) w_rel[d] = 1;
                    end
                end
                e.bubble = e.stall;
                prev_stall[d] = e.stall;
            end
            q.push_back(e);
        end
    endtask

    task automatic cyc(input bit rst_n, input bit v, input logic [5:0] o,
                       input bit mcd, input bit res, input bit xl,
                       input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk);
        #1;
        reset = rst_n; id_valid = v; op = o; mc_done = mcd; resume = res;
        ex_is_load = xl; ex_rt = xrt; id_rs = rs; id_rt = rt;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 1, 6'd0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    endtask

    // Monitor: the DUT presents a full output set every cycle. Check it mid-cycle.
    always @(negedge clk) begin
        if (q.size() >= 2) begin
            exp_t e0, e1, a0, a1;
            e0 = q.pop_front();
            e1 = q.pop_front();
            a0 = {st0, s0, b0, m0, p0, h0};
            a1 = {st1, s1, b1, m1, p1, h1};
            total++;
            if (a0 !== e0) begin
                bad++;
                $display("FAIL dut0_outputs t=%0t {state,stall,bubble,mc_start,stall_pm,halted} got=%b want=%b",
                         $time, a0, e0);
            end
            total++;
            if (a1 !== e1) begin
                bad++;
                $display("FAIL dut1_outputs t=%0t {state,stall,bubble,mc_start,stall_pm,halted} got=%b want=%b",
                         $time, a1, e1);
            end
        end
    end

    initial begin
        // Reset, then release with a quiet ID stage.
        for (int i = 0; i < 3; i++) cyc(0, 1, 6'd0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        // Load.
        cyc(1, 1, LD, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        // Jump.
        cyc(1, 1, JMP, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(4);
        // Multiply with mc_done four cycles after the start pulse, plus a stray mc_done in RUN.
        cyc(1, 1, MULT, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        cyc(1, 1, 6'd0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(2);
        cyc(1, 1, 6'd0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
        cyc(1, 1, 6'd0, 1, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(1);
        // Halt for 20 cycles while op toggles, then resume.
        cyc(1, 1, HLT, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 20; i++)
            cyc(1, 1, (i % 2) ? MULT : JMP, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        cyc(1, 1, 6'd0, 0, 1, 0, 5'd0, 5'd1, 5'd2);
        idle(2);
        // Reset asserted in the middle of MC_BUSY.
        cyc(1, 1, MULT, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(2);
        cyc(0, 1, MULT, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        cyc(0, 1, MULT, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        idle(3);
        // Load-use dependency patterns. These only stall when dependency checking is built in.
        cyc(1, 1, 6'd0, 0, 0, 1, 5'd5, 5'd5, 5'd2);
        idle(2);
        cyc(1, 1, 6'd0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        idle(1);
        cyc(1, 1, 6'd0, 0, 0, 0, 5'd5, 5'd5, 5'd5);
        idle(1);
        cyc(1, 1, HLT, 0, 0, 1, 5'd5, 5'd2, 5'd5);
        cyc(1, 1, 6'd0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
        cyc(1, 1, 6'd0, 0, 1, 0, 5'd0, 5'd1, 5'd2);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] o;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: o = HLT;
                1: o = LD;
                2: o = MULT;
                3: o = {4'b0111, 2'($urandom_range(0, 3))};
                4: o = 6'($urandom);
                default: o = 6'd0;
            endcase
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), o,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(2);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
